// File: rtl/exp_mu_job_scheduler.sv
// ---------------------------------------------------------------------------
// exp_mu_job_scheduler
//
// Shares one S0*exp(t*mu) datapath among NREQ requesters. A round-robin
// arbiter picks one (mu, S0) job at a time. The job is latched and launched
// on the datapath. The datapath's (addr, data) stream goes to a shared result
// RAM at {grant_id, t}, one cycle late. The requester is acknowledged when
// the job completes. A watchdog aborts a job whose datapath never reports
// done.
//
// Handshake: a requester raises iReq[k] and holds it high. It may drop it
// once oAck[k] pulses for one cycle. A bit still high after its ack counts
// as a new request and takes its normal round-robin turn.
//
// Ports
//   CLK, iRstN          clock; synchronous active-low reset
//   iReq[NREQ]          per-requester job request
//   iMu, iS             packed per-requester mu (0.18) and S0 (4.14)
//   oAck, oErr          one-cycle completion pulse; oErr marks a watchdog abort
//   oBusy               high whenever the scheduler is not idle
//   oDpMu, oDpS         latched operands of the granted job
//   oDpStart            one-cycle launch pulse to the datapath
//   iDpData/Addr/Valid  datapath result stream
//   iDpDone             datapath finished
//   oWrEn/Addr/Data     result RAM write port (registered)
//   oDbgState           current FSM state, for observation only
// ---------------------------------------------------------------------------
module exp_mu_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int LOGN    = 2,
  parameter int LOGT    = 9,
  parameter int TIMEOUT = 1023
) (
  input  logic                 CLK,
  input  logic                 iRstN,
  input  logic [NREQ-1:0]      iReq,
  input  logic [NREQ*18-1:0]   iMu,
  input  logic [NREQ*18-1:0]   iS,
  output logic [NREQ-1:0]      oAck,
  output logic [NREQ-1:0]      oErr,
  output logic                 oBusy,
  output logic [17:0]          oDpMu,
  output logic [17:0]          oDpS,
  output logic                 oDpStart,
  input  logic [17:0]          iDpData,
  input  logic [LOGT-1:0]      iDpAddr,
  input  logic                 iDpValid,
  input  logic                 iDpDone,
  output logic                 oWrEn,
  output logic [LOGN+LOGT-1:0] oWrAddr,
  output logic [17:0]          oWrData,
  output logic [2:0]           oDbgState
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  localparam logic [15:0]     WD_LAST = 16'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE_HOT = {{(NREQ-1){1'b0}}, 1'b1};

  state_t                 state_q;
  logic [LOGN-1:0]        rr_ptr_q;
  logic [LOGN-1:0]        grant_q;
  logic [15:0]            wd_q;
  logic                   err_q;
  logic [17:0]            mu_q;
  logic [17:0]            s_q;
  logic                   start_q;
  logic [NREQ-1:0]        ack_q;
  logic [NREQ-1:0]        err_out_q;
  logic                   wr_en_q;
  logic [LOGN+LOGT-1:0]   wr_addr_q;
  logic [17:0]            wr_data_q;

  // Round-robin pick: first set request bit at or above rr_ptr, wrapping.
  logic                   pick_found;
  logic [LOGN-1:0]        pick_id;
  logic [LOGN-1:0]        cand;

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = LOGN'((int'(rr_ptr_q) + i) % NREQ);
      if (!pick_found && iReq[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // The result stream is only accepted while a job owns the datapath;
  // DRAIN still accepts so a valid arriving with done is not lost.
  logic accept_wr;
  assign accept_wr = iDpValid && ((state_q == S_RUN) || (state_q == S_DRAIN));

  always_ff @(posedge CLK) begin
    if (!iRstN) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
      mu_q      <= '0;
      s_q       <= '0;
      start_q   <= 1'b0;
      ack_q     <= '0;
      err_out_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      start_q   <= 1'b0;
      ack_q     <= '0;
      err_out_q <= '0;

      wr_en_q <= accept_wr;
      if (accept_wr) begin
        wr_addr_q <= {grant_q, iDpAddr};
        wr_data_q <= iDpData;
      end

      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            grant_q <= pick_id;
            mu_q    <= iMu[18*pick_id +: 18];
            s_q     <= iS[18*pick_id +: 18];
            start_q <= 1'b1;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wd_q    <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          // wd_q counts RUN cycles already spent, so RUN lasts at most
          // TIMEOUT cycles before the abort.
          wd_q <= (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
          if (iDpDone) begin
            state_q <= S_DRAIN;
          end else if (wd_q >= WD_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          ack_q     <= ONE_HOT << grant_q;
          err_out_q <= err_q ? (ONE_HOT << grant_q) : '0;
          state_q   <= S_ACK;
        end
        S_ACK: begin
          rr_ptr_q <= LOGN'((int'(grant_q) + 1) % NREQ);
          err_q    <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oAck      = ack_q;
  assign oErr      = err_out_q;
  assign oBusy     = (state_q != S_IDLE);
  assign oDpMu     = mu_q;
  assign oDpS      = s_q;
  assign oDpStart  = start_q;
  assign oWrEn     = wr_en_q;
  assign oWrAddr   = wr_addr_q;
  assign oWrData   = wr_data_q;
  assign oDbgState = state_q;

endmodule

// File: tb/tb_exp_mu_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_exp_mu_job_scheduler
//
// Directed job sequence with randomized operands and result data. The
// reference keeps the round-robin pointer as an integer. Expected RAM writes
// are kept in a queue, and each job's ack cycle is derived from its done
// cycle or its watchdog limit.
// ---------------------------------------------------------------------------
module tb_exp_mu_job_scheduler;
  localparam int NREQ    = 4;
  localparam int LOGN    = 2;
  localparam int LOGT    = 9;
  localparam int TIMEOUT = 1023;
  localparam int W       = LOGN + LOGT + 18;

  // clock / reset
  logic CLK = 1'b0;
  logic iRstN = 1'b0;
  always #5 CLK = ~CLK;

  logic [NREQ-1:0]      iReq = '0;
  logic [NREQ*18-1:0]   iMu = '0;
  logic [NREQ*18-1:0]   iS = '0;
  logic [NREQ-1:0]      oAck, oErr;
  logic                 oBusy, oDpStart, oWrEn;
  logic [17:0]          oDpMu, oDpS, oWrData;
  logic [17:0]          iDpData = '0;
  logic [LOGT-1:0]      iDpAddr = '0;
  logic                 iDpValid = 1'b0;
  logic                 iDpDone = 1'b0;
  logic [LOGN+LOGT-1:0] oWrAddr;
  logic [2:0]           oDbgState;

  exp_mu_job_scheduler #(.NREQ(NREQ), .LOGN(LOGN), .LOGT(LOGT), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .iRstN(iRstN), .iReq(iReq), .iMu(iMu), .iS(iS),
    .oAck(oAck), .oErr(oErr), .oBusy(oBusy), .oDpMu(oDpMu), .oDpS(oDpS),
    .oDpStart(oDpStart), .iDpData(iDpData), .iDpAddr(iDpAddr),
    .iDpValid(iDpValid), .iDpDone(iDpDone), .oWrEn(oWrEn),
    .oWrAddr(oWrAddr), .oWrData(oWrData), .oDbgState(oDbgState)
  );

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int rr_m     = 0;
  logic [W-1:0] exp_q[$];
  logic [17:0]  mu_tab[NREQ];
  logic [17:0]  s_tab[NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every RAM write must match the oldest outstanding expected write.
  always @(negedge CLK) begin
    if (oWrEn === 1'b1) begin
      wr_cnt++;
      chk("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("write_addr_data", 32'(oWrAddr) << 18 | 32'(oWrData), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_tabs();
    for (int k = 0; k < NREQ; k++) begin
      iMu[18*k +: 18] = mu_tab[k];
      iS[18*k +: 18]  = s_tab[k];
    end
  endtask

  task automatic rand_tabs();
    for (int k = 0; k < NREQ; k++) begin
      mu_tab[k] = 18'($urandom);
      s_tab[k]  = 18'($urandom);
    end
    apply_tabs();
  endtask

  // Round-robin rule: first requester at or above the pointer, wrapping.
  function automatic int pick(input logic [NREQ-1:0] req);
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (rr_m + i) % NREQ;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(oAck), 32'd0);
    chk({tag, "_err"}, 32'(oErr), 32'd0);
    chk({tag, "_busy"}, 32'(oBusy), 32'd0);
    chk({tag, "_mu"}, 32'(oDpMu), 32'd0);
    chk({tag, "_s"}, 32'(oDpS), 32'd0);
    chk({tag, "_start"}, 32'(oDpStart), 32'd0);
    chk({tag, "_wren"}, 32'(oWrEn), 32'd0);
    chk({tag, "_wraddr"}, 32'(oWrAddr), 32'd0);
    chk({tag, "_wrdata"}, 32'(oWrData), 32'd0);
  endtask

  task automatic do_reset();
    iRstN = 1'b0;
    iReq = '0;
    iDpValid = 1'b0;
    iDpDone = 1'b0;
    tick();
    @(negedge CLK);
    check_all_zero("reset");
    tick();
    iRstN = 1'b1;
    rr_m = 0;
  endtask

  // Waits for the launch pulse; lat is the expected negedge index (0-based).
  task automatic wait_start(input int lat, output bit ok);
    int c;
    ok = 1'b0;
    for (c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (oDpStart === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("start_seen", 32'(ok), 32'd1);
    if (ok) chk("start_latency", 32'(c), 32'(lat));
  endtask

  // One complete job: launch, n results from first_t, done (with the last
  // valid, a cycle later, or never when tmo), then ack. drop clears iReq bits
  // at the ack; stray pulses datapath valid/done while the scheduler is idle.
  task automatic run_job(input int gid, input int lat, input int first_t, input int n,
                         input bit done_last, input bit tmo,
                         input logic [NREQ-1:0] drop, input bit stray);
    bit ok;
    int cur, ack_idx, wr0;
    logic [17:0] emu, es, d;
    emu = mu_tab[gid];
    es  = s_tab[gid];
    wr0 = wr_cnt;
    wait_start(lat, ok);
    if (!ok) return;
    chk("dp_mu_at_launch", 32'(oDpMu), 32'(emu));
    chk("dp_s_at_launch", 32'(oDpS), 32'(es));
    chk("busy_at_launch", 32'(oBusy), 32'd1);
    tick();
    for (int i = 0; i < n; i++) begin
      d = 18'($urandom);
      iDpValid = 1'b1;
      iDpAddr  = LOGT'(first_t + i);
      iDpData  = d;
      iDpDone  = done_last && (i == n - 1);
      exp_q.push_back({LOGN'(gid), LOGT'(first_t + i), d});
      if (i == n / 2) rand_tabs();
      @(negedge CLK);
      if (i == 0) chk("start_one_cycle", 32'(oDpStart), 32'd0);
      tick();
    end
    iDpValid = 1'b0;
    if (tmo) begin
      ack_idx = TIMEOUT + 2;
      cur = n + 1;
    end else if (done_last) begin
      ack_idx = n + 2;
      cur = n + 1;
    end else begin
      iDpDone = 1'b1;
      tick();
      ack_idx = n + 3;
      cur = n + 2;
    end
    iDpDone = 1'b0;
    for (int c = cur; c < ack_idx; c++) begin
      @(negedge CLK);
      chk("no_early_ack", 32'(oAck), 32'd0);
    end
    @(negedge CLK);
    chk("ack_onehot", 32'(oAck), 32'(1 << gid));
    chk("err_flag", 32'(oErr), tmo ? 32'(1 << gid) : 32'd0);
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    chk("write_count", 32'(wr_cnt - wr0), 32'(n));
    chk("dp_mu_held", 32'(oDpMu), 32'(emu));
    chk("dp_s_held", 32'(oDpS), 32'(es));
    rr_m = (gid + 1) % NREQ;
    iReq = iReq & ~drop;
    tick();
    if (stray) begin
      iDpValid = 1'b1;
      iDpDone  = 1'b1;
      iDpAddr  = LOGT'($urandom);
      iDpData  = 18'($urandom);
    end
    @(negedge CLK);
    chk("idle_after_ack", 32'(oBusy), 32'd0);
    chk("ack_single_pulse", 32'(oAck), 32'd0);
    tick();
    iDpValid = 1'b0;
    iDpDone  = 1'b0;
  endtask

  initial begin
    int g;
    int wr0;
    for (int k = 0; k < NREQ; k++) begin
      mu_tab[k] = '0;
      s_tab[k]  = '0;
    end
    apply_tabs();
    do_reset();

    // single job, fixed operands, done one cycle after the last valid
    mu_tab[0] = 18'h00100;
    s_tab[0]  = 18'h04000;
    apply_tabs();
    iReq = 4'b0001;
    g = pick(iReq);
    run_job(g, 1, 171, 171, 1'b0, 1'b0, 4'b0001, 1'b0);

    // done shares the cycle with the last valid (t=341)
    mu_tab[0] = 18'h00100;
    s_tab[0]  = 18'h04000;
    apply_tabs();
    iReq = 4'b0001;
    g = pick(iReq);
    run_job(g, 1, 171, 171, 1'b1, 1'b0, 4'b0001, 1'b0);

    // three held requests from a fresh pointer, each dropped at its ack
    do_reset();
    rand_tabs();
    iReq = 4'b1011;
    for (int j = 0; j < 3; j++) begin
      g = pick(iReq);
      run_job(g, (j == 0) ? 1 : 0, $urandom_range(0, 500), $urandom_range(1, 8),
              1'($urandom), 1'b0, NREQ'(1 << g), 1'b0);
    end

    // all four held for eight jobs, stray datapath pulses while idle
    rand_tabs();
    iReq = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      g = pick(iReq);
      run_job(g, (j == 0) ? 1 : 0, $urandom_range(0, 500), $urandom_range(1, 8),
              1'($urandom), 1'b0, (j == 7) ? 4'b1111 : 4'b0000, 1'b1);
    end

    // datapath never reports done: watchdog abort
    rand_tabs();
    iReq = 4'b0010;
    g = pick(iReq);
    run_job(g, 1, 10, 5, 1'b0, 1'b1, 4'b0010, 1'b0);

    // reset in the middle of a job at t=250, then re-grant from pointer 0
    begin
      bit ok;
      logic [17:0] d;
      rand_tabs();
      iReq = 4'b0101;
      g = pick(iReq);
      wait_start(1, ok);
      chk("rst_job_mu", 32'(oDpMu), 32'(mu_tab[g]));
      tick();
      for (int t = 171; t < 250; t++) begin
        d = 18'($urandom);
        iDpValid = 1'b1;
        iDpAddr  = LOGT'(t);
        iDpData  = d;
        exp_q.push_back({LOGN'(g), LOGT'(t), d});
        tick();
      end
      iDpAddr  = LOGT'(250);
      iDpData  = 18'($urandom);
      iRstN    = 1'b0;
      tick();
      iRstN    = 1'b1;
      iDpValid = 1'b0;
      rr_m     = 0;
      @(negedge CLK);
      check_all_zero("mid_run_reset");
      chk("mid_run_reset_queue", 32'(exp_q.size()), 32'd0);
      wr0 = wr_cnt;
      g = pick(iReq);
      run_job(g, 0, 0, 4, 1'b0, 1'b0, NREQ'(1 << g), 1'b0);
      g = pick(iReq);
      run_job(g, 0, 0, 4, 1'b1, 1'b0, NREQ'(1 << g), 1'b0);
      chk("post_reset_writes", 32'(wr_cnt - wr0), 32'd8);
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
